// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX arbiter slice.
// Exports: arbiter state enum, default sizes, grant index type.
package uart_arb_pkg;

   localparam int ARB_NUM_REQ      = 3;
   localparam int ARB_DATA_W       = 8;
   localparam int ARB_HOLD_TIMEOUT = 12000;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   typedef logic [$clog2(ARB_NUM_REQ)-1:0] grant_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between requesters, arbiter and TX serializer.
// master: requesters + serializer side; slave: the arbiter.
interface uart_tx_arb_if
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ,
   parameter int DATA_W  = ARB_DATA_W
);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      tx_valid;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_ready;

   modport master (
      output req_valid, req_data, req_last, tx_ready,
      input  req_ready, tx_valid, tx_data
   );

   modport slave (
      input  req_valid, req_data, req_last, tx_ready,
      output req_ready, tx_valid, tx_data
   );

endinterface

// File: rtl/rr_picker.sv
// Round-robin picker: first valid index after last_grant, wrapping.
// Ports: req_valid, last_grant in; pick, any out. Pure combinational.
module rr_picker #(
   parameter int N = 3
) (
   input  logic [N-1:0]         req_valid,
   input  logic [$clog2(N)-1:0] last_grant,
   output logic [$clog2(N)-1:0] pick,
   output logic                 any
);

   localparam int GW = $clog2(N);

   logic [GW-1:0] idx;

   // Scan from farthest to nearest so the nearest valid wins.
   always_comb begin
      pick = '0;
      any  = 1'b0;
      idx  = '0;
      for (int k = N; k >= 1; k--) begin
         idx = GW'((int'(last_grant) + k) % N);
         if (req_valid[idx]) begin
            pick = idx;
            any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between NUM_REQ byte requesters.
// Ports: clk_12p0, rst_n, bus (slave), grant_id, busy, timeout_pulse.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ      = ARB_NUM_REQ,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int HOLD_TIMEOUT = ARB_HOLD_TIMEOUT
) (
   input  logic                       clk_12p0,
   input  logic                       rst_n,
   uart_tx_arb_if.slave               bus,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       busy,
   output logic                       timeout_pulse
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int TW = $clog2(HOLD_TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(HOLD_TIMEOUT - 1);
   localparam logic [GW-1:0] G_INIT = GW'(NUM_REQ - 1);

   arb_state_e        state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     last_grant_q, last_grant_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              tx_valid_q, tx_valid_d;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   logic              pulse_q, pulse_d;

   logic [GW-1:0]     pick;
   logic              any;
   logic              slot_free;
   logic              hold_valid;
   logic              hold_last;
   logic [DATA_W-1:0] hold_data;
   logic              hs;

   rr_picker #(.N(NUM_REQ)) u_pick (
      .req_valid  (bus.req_valid),
      .last_grant (last_grant_q),
      .pick       (pick),
      .any        (any)
   );

   // Output register can take a byte if empty or draining now.
   assign slot_free  = !tx_valid_q || bus.tx_ready;
   assign hold_valid = bus.req_valid[grant_q];
   assign hold_last  = bus.req_last[grant_q];
   assign hold_data  = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];
   assign hs = (state_q == LOCKED) && hold_valid && slot_free;

   always_comb begin
      bus.req_ready = '0;
      if (state_q == LOCKED && slot_free)
         bus.req_ready[grant_q] = 1'b1;
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      timer_d      = timer_q;
      pulse_d      = 1'b0;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;

      if (hs) begin
         tx_valid_d = 1'b1;
         tx_data_d  = hold_data;
      end else if (bus.tx_ready) begin
         tx_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (any) begin
               grant_d = pick;
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (hs) begin
               timer_d = '0;
               if (hold_last) begin
                  state_d      = IDLE;
                  last_grant_d = grant_q;
               end
            end else if (timer_q == T_LAST) begin
               // Forced release; a byte already in the
               // output register still drains normally.
               state_d      = IDLE;
               last_grant_d = grant_q;
               pulse_d      = 1'b1;
               timer_d      = '0;
            end else if (!hold_valid) begin
               // Only starvation counts; backpressure holds.
               timer_d = timer_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_12p0 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= G_INIT;
         timer_q      <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         pulse_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         timer_q      <= timer_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         pulse_q      <= pulse_d;
      end
   end

   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_data   = tx_data_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q == LOCKED);
   assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter (3 requesters, 8-bit bytes).
// Driver feeds per-requester queues; monitor checks tx bytes in order.
module tb_uart_tx_arbiter;

   typedef struct packed {
      logic       last;
      logic [7:0] d;
   } beat_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant_id;
   logic       busy;
   logic       timeout_pulse;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int pulses = 0;

   beat_t      src_q[3][$];
   logic [7:0] exp_q[$];
   int         stamps[$];
   int         glog[$];
   logic [2:0] fire = '0;
   logic       busy_prev = 1'b0;

   uart_tx_arb_if #(.NUM_REQ(3), .DATA_W(8)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(3), .DATA_W(8), .HOLD_TIMEOUT(12000)
   ) dut (
      .clk_12p0      (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .grant_id      (grant_id),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic push_src(int r, logic [7:0] d, logic l);
      src_q[r].push_back({l, d});
   endtask

   task automatic push_exp(logic [7:0] d);
      exp_q.push_back(d);
   endtask

   function automatic bit src_empty();
      return src_q[0].size() == 0 && src_q[1].size() == 0 &&
             src_q[2].size() == 0;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < 3; i++) begin
         if (rst_n && src_q[i].size() > 0) begin
            bus.req_valid[i]         = 1'b1;
            bus.req_data[i*8 +: 8]   = src_q[i][0].d;
            bus.req_last[i]          = src_q[i][0].last;
         end else begin
            bus.req_valid[i]         = 1'b0;
            bus.req_data[i*8 +: 8]   = 8'h00;
            bus.req_last[i]          = 1'b0;
         end
      end
   endtask

   // Requester driver: retire accepted beats, present next ones.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++)
         if (fire[i] && src_q[i].size() > 0)
            void'(src_q[i].pop_front());
      drive_reqs();
   end

   // Monitor: every tx transfer is checked against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      fire = bus.req_valid & bus.req_ready;
      if (rst_n) begin
         if (bus.tx_valid && bus.tx_ready) begin
            stamps.push_back(cyc);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_extra: got 0x%0h, expected none",
                        bus.tx_data);
            end else begin
               chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
         end
         if (busy && !busy_prev) glog.push_back(int'(grant_id));
         if (timeout_pulse) pulses++;
      end
      busy_prev = busy;
   end

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_all();
      for (int i = 0; i < 3; i++) src_q[i].delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      clear_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      glog.delete();
      stamps.delete();
      pulses = 0;
      nstep();
   endtask

   task automatic wait_drain(string nm, int budget);
      int n = 0;
      while ((exp_q.size() != 0 || !src_empty() || bus.tx_valid) &&
             n < budget) begin
         nstep();
         n++;
      end
      chk(nm, 32'(n < budget), 32'd1);
   endtask

   task automatic chk_glog(string nm, int exp[$]);
      chk({nm, "_len"}, glog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < glog.size(); i++)
         chk(nm, glog[i], exp[i]);
   endtask

   task automatic chk_gaps(string nm, int n, int gap);
      chk({nm, "_cnt"}, stamps.size(), n);
      for (int i = 1; i < n && i < stamps.size(); i++)
         chk(nm, stamps[i] - stamps[i-1], gap);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n, k, idle, bad_rdy, bad_data, bad_to;
      bit loaded;

      rst_n = 1'b0;
      bus.tx_ready  = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;
      repeat (3) nstep();
      chk("rst_tx_valid", bus.tx_valid, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulse", timeout_pulse, 0);
      rst_n = 1'b1;
      nstep();

      // 1: three-byte message, full throughput
      stamps.delete();
      push_src(0, 8'h48, 0); push_src(0, 8'h69, 0);
      push_src(0, 8'h0A, 1);
      push_exp(8'h48); push_exp(8'h69); push_exp(8'h0A);
      n = 0;
      while (!bus.req_valid[0] && n < 10) begin nstep(); n++; end
      k = 0;
      while (!bus.tx_valid && k < 10) begin nstep(); k++; end
      chk("t1_latency", k, 2);
      wait_drain("t1_drain", 100);
      chk_gaps("t1_gap", 3, 1);

      // 2: req0 and req2 contend, no interleave
      do_reset();
      push_src(0, 8'h21, 0); push_src(0, 8'h22, 1);
      push_src(2, 8'h23, 0); push_src(2, 8'h24, 1);
      push_exp(8'h21); push_exp(8'h22);
      push_exp(8'h23); push_exp(8'h24);
      wait_drain("t2_drain", 100);
      chk_glog("t2_grant", '{0, 2});

      // 3: stalled holder released by watchdog
      do_reset();
      push_src(1, 8'h11, 0);
      push_exp(8'h11);
      idle = 0; n = 0; loaded = 0;
      while (!timeout_pulse && n < 13000) begin
         nstep();
         n++;
         if (busy && !loaded) begin
            push_src(0, 8'h30, 0); push_src(0, 8'h31, 1);
            push_exp(8'h30); push_exp(8'h31);
            loaded = 1;
         end
         if (busy && grant_id == 2'd1 && !bus.req_valid[1]) idle++;
      end
      chk("t3_pulse_seen", timeout_pulse, 1);
      chk("t3_idle_cycles", idle, 12000);
      chk("t3_busy_released", busy, 0);
      wait_drain("t3_drain", 100);
      chk_glog("t3_grant", '{1, 0});
      chk("t3_pulse_count", pulses, 1);

      // 4: 50 cycles of serializer backpressure mid-message
      do_reset();
      push_src(0, 8'h40, 0); push_src(0, 8'h41, 0);
      push_src(0, 8'h42, 0); push_src(0, 8'h43, 1);
      push_exp(8'h40); push_exp(8'h41);
      push_exp(8'h42); push_exp(8'h43);
      n = 0;
      while (stamps.size() < 2 && n < 50) begin nstep(); n++; end
      @(posedge clk);
      #1;
      bus.tx_ready = 1'b0;
      bad_rdy = 0; bad_data = 0; bad_to = 0;
      repeat (50) begin
         nstep();
         if (bus.req_ready != 3'b000) bad_rdy++;
         if (!bus.tx_valid || bus.tx_data !== 8'h42) bad_data++;
         if (timeout_pulse) bad_to++;
      end
      chk("t4_ready_low", bad_rdy, 0);
      chk("t4_data_stable", bad_data, 0);
      chk("t4_no_timeout", bad_to, 0);
      chk("t4_lock_held", busy, 1);
      @(posedge clk);
      #1;
      bus.tx_ready = 1'b1;
      wait_drain("t4_drain", 100);
      chk("t4_pulses", pulses, 0);

      // 5: async reset with a byte in the output register
      do_reset();
      bus.tx_ready = 1'b0;
      push_src(0, 8'h50, 0); push_src(0, 8'h51, 0);
      push_src(0, 8'h52, 1);
      n = 0;
      while (!bus.tx_valid && n < 20) begin nstep(); n++; end
      chk("t5_loaded", bus.tx_valid, 1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t5_async_tx_valid", bus.tx_valid, 0);
      chk("t5_async_busy", busy, 0);
      clear_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus.tx_ready = 1'b1;
      glog.delete();
      nstep();
      push_src(1, 8'h71, 1); push_src(0, 8'h70, 1);
      push_exp(8'h70); push_exp(8'h71);
      wait_drain("t5_drain", 100);
      chk_glog("t5_grant", '{0, 1});

      // 6: all requesters busy with one-byte messages
      do_reset();
      push_src(0, 8'h60, 1); push_src(0, 8'h63, 1);
      push_src(1, 8'h61, 1); push_src(1, 8'h64, 1);
      push_src(2, 8'h62, 1); push_src(2, 8'h65, 1);
      for (int b = 8'h60; b <= 8'h65; b++) push_exp(8'(b));
      wait_drain("t6_drain", 100);
      chk_glog("t6_grant", '{0, 1, 2, 0, 1, 2});
      chk_gaps("t6_gap", 6, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
